// File: rtl/state_dump_ctrl.sv
// Run-and-dump controller: resets the core, runs it for a bounded window, then
// streams int regs, RNS regs and non-zero memory words out over valid/ready.
module state_dump_ctrl #(
  parameter int DATA_W       = 16,
  parameter int INT_REGS     = 8,
  parameter int RNS_REGS     = 8,
  parameter int MEM_AW       = 16,
  parameter int RESET_CYCLES = 5,
  parameter int RUN_CYCLES   = 95,
  parameter int SKIP_ZERO    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              core_halt,
  output logic              core_reset,
  output logic              core_run,
  output logic [1:0]        rd_sel,
  output logic [MEM_AW-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [1:0]        dump_kind,
  output logic [MEM_AW-1:0] dump_index,
  output logic [DATA_W-1:0] dump_data,
  output logic              busy,
  output logic              done,
  output logic              timed_out,
  output logic [31:0]       cycle_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_RST, S_RUN, S_ISSUE, S_WAIT, S_EMIT, S_DONE
  } state_t;

  localparam logic [1:0] SEL_INT = 2'd0;
  localparam logic [1:0] SEL_RNS = 2'd1;
  localparam logic [1:0] SEL_MEM = 2'd2;

  localparam logic [1:0] FIRST_SEL = (INT_REGS > 0) ? SEL_INT :
                                     (RNS_REGS > 0) ? SEL_RNS : SEL_MEM;
  localparam logic [MEM_AW-1:0] INT_LAST = MEM_AW'(INT_REGS - 1);
  localparam logic [MEM_AW-1:0] RNS_LAST = MEM_AW'(RNS_REGS - 1);
  localparam logic [31:0]       RST_LAST = (RESET_CYCLES > 0) ? 32'(RESET_CYCLES - 1) : 32'd0;
  localparam logic [32:0]       RUN_LIM  = 33'(RUN_CYCLES);

  state_t              state_q, state_d;
  logic [31:0]         rst_cnt_q, rst_cnt_d;
  logic [31:0]         cycle_count_q, cycle_count_d;
  logic                timed_out_q, timed_out_d;
  logic [1:0]          rd_sel_q, rd_sel_d;
  logic [MEM_AW-1:0]   rd_addr_q, rd_addr_d;
  logic [1:0]          dump_kind_q, dump_kind_d;
  logic [MEM_AW-1:0]   dump_index_q, dump_index_d;
  logic [DATA_W-1:0]   dump_data_q, dump_data_d;

  logic [1:0]          adv_sel;
  logic [MEM_AW-1:0]   adv_addr;
  logic                adv_end;
  logic                run_end;
  logic                skip_word;

  // Successor of the current read position in dump order; empty arrays are hopped over.
  always_comb begin
    adv_sel  = rd_sel_q;
    adv_addr = rd_addr_q + 1'b1;
    adv_end  = 1'b0;
    case (rd_sel_q)
      SEL_INT: begin
        if (rd_addr_q == INT_LAST) begin
          adv_sel  = (RNS_REGS > 0) ? SEL_RNS : SEL_MEM;
          adv_addr = '0;
        end
      end
      SEL_RNS: begin
        if (rd_addr_q == RNS_LAST) begin
          adv_sel  = SEL_MEM;
          adv_addr = '0;
        end
      end
      default: begin
        if (rd_addr_q == '1) begin
          adv_end = 1'b1;
        end
      end
    endcase
  end

  assign run_end   = core_halt || (({1'b0, cycle_count_q} + 33'd1) >= RUN_LIM);
  assign skip_word = (SKIP_ZERO != 0) && (rd_sel_q == SEL_MEM) && (rd_data == '0);

  always_comb begin
    state_d       = state_q;
    rst_cnt_d     = rst_cnt_q;
    cycle_count_d = cycle_count_q;
    timed_out_d   = timed_out_q;
    rd_sel_d      = rd_sel_q;
    rd_addr_d     = rd_addr_q;
    dump_kind_d   = dump_kind_q;
    dump_index_d  = dump_index_q;
    dump_data_d   = dump_data_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d       = S_RST;
          rst_cnt_d     = '0;
          cycle_count_d = '0;
          timed_out_d   = 1'b0;
        end
      end
      S_RST: begin
        rst_cnt_d = rst_cnt_q + 32'd1;
        if (rst_cnt_q >= RST_LAST) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (cycle_count_q != '1) begin
          cycle_count_d = cycle_count_q + 32'd1;
        end
        if (run_end) begin
          // A halt arriving on the timeout cycle still counts as a clean halt.
          timed_out_d = !core_halt;
          state_d     = S_ISSUE;
          rd_sel_d    = FIRST_SEL;
          rd_addr_d   = '0;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (skip_word) begin
          if (adv_end) begin
            state_d = S_DONE;
          end else begin
            state_d   = S_ISSUE;
            rd_sel_d  = adv_sel;
            rd_addr_d = adv_addr;
          end
        end else begin
          state_d      = S_EMIT;
          dump_kind_d  = rd_sel_q;
          dump_index_d = rd_addr_q;
          dump_data_d  = rd_data;
        end
      end
      S_EMIT: begin
        if (dump_ready) begin
          if (adv_end) begin
            state_d = S_DONE;
          end else begin
            state_d   = S_ISSUE;
            rd_sel_d  = adv_sel;
            rd_addr_d = adv_addr;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      rst_cnt_q     <= '0;
      cycle_count_q <= '0;
      timed_out_q   <= 1'b0;
      rd_sel_q      <= '0;
      rd_addr_q     <= '0;
      dump_kind_q   <= '0;
      dump_index_q  <= '0;
      dump_data_q   <= '0;
    end else begin
      state_q       <= state_d;
      rst_cnt_q     <= rst_cnt_d;
      cycle_count_q <= cycle_count_d;
      timed_out_q   <= timed_out_d;
      rd_sel_q      <= rd_sel_d;
      rd_addr_q     <= rd_addr_d;
      dump_kind_q   <= dump_kind_d;
      dump_index_q  <= dump_index_d;
      dump_data_q   <= dump_data_d;
    end
  end

  // Core is held in reset until the first run; after that it stays frozen.
  assign core_reset  = (state_q == S_IDLE) || (state_q == S_RST);
  assign core_run    = (state_q == S_RUN);
  assign busy        = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done        = (state_q == S_DONE);
  assign dump_valid  = (state_q == S_EMIT);
  assign rd_sel      = rd_sel_q;
  assign rd_addr     = rd_addr_q;
  assign dump_kind   = dump_kind_q;
  assign dump_index  = dump_index_q;
  assign dump_data   = dump_data_q;
  assign timed_out   = timed_out_q;
  assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_state_dump_ctrl.sv
// Directed bench for state_dump_ctrl: run window, halt, dump order, zero skip,
// backpressure and mid-dump reset, on a SKIP_ZERO=1 and a SKIP_ZERO=0 instance.
module tb_state_dump_ctrl;
  localparam int DW = 16;
  localparam int AW = 4;

  typedef logic [2+AW+DW-1:0] beat_t;

  logic clk = 1'b0;
  logic reset, start, core_halt, dump_ready;

  logic          core_reset, core_run, dump_valid, busy, done, timed_out;
  logic [1:0]    rd_sel, dump_kind;
  logic [AW-1:0] rd_addr, dump_index;
  logic [DW-1:0] rd_data, dump_data;
  logic [31:0]   cycle_count;

  logic          core_reset_n, core_run_n, dump_valid_n, busy_n, done_n, timed_out_n;
  logic [1:0]    rd_sel_n, dump_kind_n;
  logic [AW-1:0] rd_addr_n, dump_index_n;
  logic [DW-1:0] rd_data_n, dump_data_n;
  logic [31:0]   cycle_count_n;

  logic [DW-1:0] int_regs [8];
  logic [DW-1:0] rns_regs [8];
  logic [DW-1:0] mem      [16];

  beat_t beats[$], beats_n[$], exp_q[$], exp_n[$];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  state_dump_ctrl #(.DATA_W(DW), .INT_REGS(8), .RNS_REGS(8), .MEM_AW(AW),
                    .RESET_CYCLES(5), .RUN_CYCLES(95), .SKIP_ZERO(1)) dut (
    .clk(clk), .reset(reset), .start(start), .core_halt(core_halt),
    .core_reset(core_reset), .core_run(core_run), .rd_sel(rd_sel), .rd_addr(rd_addr),
    .rd_data(rd_data), .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_kind(dump_kind), .dump_index(dump_index), .dump_data(dump_data),
    .busy(busy), .done(done), .timed_out(timed_out), .cycle_count(cycle_count));

  state_dump_ctrl #(.DATA_W(DW), .INT_REGS(8), .RNS_REGS(8), .MEM_AW(AW),
                    .RESET_CYCLES(5), .RUN_CYCLES(95), .SKIP_ZERO(0)) dut_ns (
    .clk(clk), .reset(reset), .start(start), .core_halt(core_halt),
    .core_reset(core_reset_n), .core_run(core_run_n), .rd_sel(rd_sel_n), .rd_addr(rd_addr_n),
    .rd_data(rd_data_n), .dump_valid(dump_valid_n), .dump_ready(dump_ready),
    .dump_kind(dump_kind_n), .dump_index(dump_index_n), .dump_data(dump_data_n),
    .busy(busy_n), .done(done_n), .timed_out(timed_out_n), .cycle_count(cycle_count_n));

  function automatic logic [DW-1:0] rd_model(input logic [1:0] s, input logic [AW-1:0] a);
    logic [DW-1:0] v;
    v = '0;
    case (s)
      2'd0: if (a < 8) v = int_regs[a[2:0]];
      2'd1: if (a < 8) v = rns_regs[a[2:0]];
      2'd2: v = mem[a];
      default: v = '0;
    endcase
    return v;
  endfunction

  // Synchronous-read array model plus beat collectors.
  always @(posedge clk) begin
    rd_data   <= rd_model(rd_sel, rd_addr);
    rd_data_n <= rd_model(rd_sel_n, rd_addr_n);
    if (dump_valid && dump_ready)   beats.push_back({dump_kind, dump_index, dump_data});
    if (dump_valid_n && dump_ready) beats_n.push_back({dump_kind_n, dump_index_n, dump_data_n});
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_run();
    int n;
    n = 0;
    while (!core_run && n < 50) begin tick(); n++; end
    chk("run_reached", core_run, 1'b1);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!(done && done_n) && n < 2000) begin tick(); n++; end
    chk("done_skip", done, 1'b1);
    chk("done_noskip", done_n, 1'b1);
  endtask

  task automatic check_beats();
    chk("beat_count_skip", beats.size(), exp_q.size());
    for (int i = 0; i < beats.size() && i < exp_q.size(); i++)
      chk($sformatf("beat_skip[%0d]", i), beats[i], exp_q[i]);
    chk("beat_count_noskip", beats_n.size(), exp_n.size());
    for (int i = 0; i < beats_n.size() && i < exp_n.size(); i++)
      chk($sformatf("beat_noskip[%0d]", i), beats_n[i], exp_n[i]);
  endtask

  initial begin
    int n;
    beat_t held;
    logic stable;

    reset = 1'b1; start = 1'b0; core_halt = 1'b0; dump_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin int_regs[i] = '0; rns_regs[i] = '0; end
    for (int i = 0; i < 16; i++) mem[i] = '0;
    int_regs[3] = 16'd42;
    rns_regs[2] = 16'hA55A;
    mem[5]      = 16'd7;
    mem[15]     = 16'd9;

    // Hand-written dump order: regs always, memory only where non-zero when skipping.
    for (int i = 0; i < 8; i++) exp_q.push_back({2'd0, 4'(i), (i == 3) ? 16'd42 : 16'd0});
    for (int i = 0; i < 8; i++) exp_q.push_back({2'd1, 4'(i), (i == 2) ? 16'hA55A : 16'd0});
    exp_n = exp_q;
    exp_q.push_back({2'd2, 4'd5, 16'd7});
    exp_q.push_back({2'd2, 4'd15, 16'd9});
    for (int i = 0; i < 16; i++)
      exp_n.push_back({2'd2, 4'(i), (i == 5) ? 16'd7 : (i == 15) ? 16'd9 : 16'd0});

    tick(); tick();
    chk("rst_core_reset", core_reset, 1'b1);
    chk("rst_core_run", core_run, 1'b0);
    chk("rst_dump_valid", dump_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_timed_out", timed_out, 1'b0);
    chk("rst_cycle_count", cycle_count, 32'd0);
    chk("rst_rd_sel_addr", {rd_sel, rd_addr}, '0);
    chk("rst_dump_fields", {dump_kind, dump_index, dump_data}, '0);
    reset = 1'b0;
    tick();
    chk("idle_after_reset", {busy, done}, 2'b00);

    // Full timeout run.
    pulse_start();
    chk("start_busy", busy, 1'b1);
    n = 0;
    while (core_reset && n < 20) begin n++; tick(); end
    chk("reset_cycles", n, 5);
    n = 0;
    while (core_run && n < 200) begin n++; tick(); end
    chk("run_cycles", n, 95);
    chk("timeout_flag", timed_out, 1'b1);
    chk("timeout_count", cycle_count, 32'd95);
    chk("dump_frozen", {core_reset, core_run, busy}, 3'b001);
    wait_done();
    check_beats();
    chk("done_idle", {busy, core_reset, core_run}, 3'b000);

    // Halt at run cycle 10, with a stalled first beat and an ignored start.
    beats.delete(); beats_n.delete();
    pulse_start();
    chk("restart_clears", {done, timed_out, cycle_count}, 34'd0);
    wait_run();
    repeat (9) tick();
    core_halt = 1'b1;
    tick();
    core_halt = 1'b0;
    dump_ready = 1'b0;
    chk("halt_run_low", core_run, 1'b0);
    chk("halt_count", cycle_count, 32'd10);
    chk("halt_not_timeout", timed_out, 1'b0);
    n = 0;
    while (!dump_valid && n < 20) begin tick(); n++; end
    chk("stall_valid", dump_valid, 1'b1);
    held = {dump_kind, dump_index, dump_data};
    chk("stall_first_beat", held, {2'd0, 4'd0, 16'd0});
    stable = 1'b1;
    repeat (20) begin
      tick();
      if (!dump_valid || {dump_kind, dump_index, dump_data} !== held) stable = 1'b0;
    end
    chk("stall_stable", stable, 1'b1);
    chk("stall_no_beat", beats.size(), 0);
    dump_ready = 1'b1;
    repeat (10) tick();
    pulse_start();
    chk("busy_start_ignored", {busy, cycle_count}, {1'b1, 32'd10});
    wait_done();
    check_beats();
    chk("halt_count_kept", cycle_count, 32'd10);

    // Halt coinciding with timeout, then reset in the middle of the dump.
    beats.delete(); beats_n.delete();
    pulse_start();
    wait_run();
    repeat (94) tick();
    core_halt = 1'b1;
    tick();
    core_halt = 1'b0;
    chk("tie_not_timeout", timed_out, 1'b0);
    chk("tie_count", cycle_count, 32'd95);
    chk("tie_run_low", core_run, 1'b0);
    n = 0;
    while (rd_sel != 2'd1 && n < 200) begin tick(); n++; end
    chk("reached_rns", rd_sel, 2'd1);
    reset = 1'b1;
    #1;
    chk("abort_outputs", {busy, dump_valid, core_reset, core_run, done}, 5'b00100);
    chk("abort_count", cycle_count, 32'd0);
    chk("abort_rd", {rd_sel, rd_addr}, '0);
    tick();
    reset = 1'b0;
    beats.delete(); beats_n.delete();
    tick();
    pulse_start();
    wait_done();
    chk("rerun_timeout", timed_out, 1'b1);
    chk("rerun_count", cycle_count, 32'd95);
    check_beats();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
